// File: rtl/bram_image_writer.sv
// bram_image_writer: loads a frame of pixel bytes from a byte stream into a
// BRAM write port. A frame begins after a 0xAA sync byte. While idle, the
// block also services single-pixel paint requests.
// Optional build macro PACKED_INPUT_EN: each load byte carries two pixels
// ([6:4] first, [2:0] second). Frames are assumed to hold an even number
// of pixels in this mode.
module bram_image_writer #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        clk_25mhz,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        start_load,
   input  logic        paint_req,
   input  logic [9:0]  paint_x,
   input  logic [9:0]  paint_y,
   input  logic [2:0]  paint_color,
   output logic        paint_ack,
   output logic        bram_we,
   output logic [18:0] bram_addr,
   output logic [7:0]  bram_wdata,
   output logic        busy,
   output logic        frame_done,
   output logic [18:0] pixel_count
);

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_SYNC = 2'd1;
   localparam logic [1:0]  ST_LOAD = 2'd2;
   localparam logic [1:0]  ST_DONE = 2'd3;

   localparam logic [18:0] LAST_ADDR  = 19'(IMG_W * IMG_H - 1);
   localparam logic [18:0] IMG_W_ADDR = 19'(IMG_W);
   localparam logic [10:0] IMG_W_LIM  = 11'(IMG_W);
   localparam logic [10:0] IMG_H_LIM  = 11'(IMG_H);
   localparam logic [7:0]  SYNC_BYTE  = 8'hAA;

   logic [1:0]  state_r;
   logic [18:0] addr_r;
   logic        accept_s;
   logic [18:0] paint_addr_s;
   logic        paint_in_range_s;
`ifdef PACKED_INPUT_EN
   // phase 0: ready for a byte, 1: second pixel pending, 2: recovery cycle
   logic [1:0]  phase_r;
   logic [2:0]  low_pix_r;
`endif

   assign accept_s = rx_valid & rx_ready;

   // Paint address and bounds; the 640-wide case uses shift-add instead of a multiplier.
   always_comb begin
      paint_addr_s = 19'd0;
      if (IMG_W == 640) begin
         paint_addr_s = {paint_y, 9'd0} + {2'd0, paint_y, 7'd0} + {9'd0, paint_x};
      end else begin
         paint_addr_s = 19'({9'd0, paint_y} * IMG_W_ADDR);
         paint_addr_s = paint_addr_s + {9'd0, paint_x};
      end
      paint_in_range_s = ({1'b0, paint_x} < IMG_W_LIM) && ({1'b0, paint_y} < IMG_H_LIM);
   end

   // Control FSM with all outputs registered; write strobes default low every cycle.
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= 19'd0;
         rx_ready    <= 1'b0;
         bram_we     <= 1'b0;
         bram_addr   <= 19'd0;
         bram_wdata  <= 8'd0;
         paint_ack   <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         pixel_count <= 19'd0;
`ifdef PACKED_INPUT_EN
         phase_r     <= 2'd0;
         low_pix_r   <= 3'd0;
`endif
      end else begin
         bram_we    <= 1'b0;
         paint_ack  <= 1'b0;
         frame_done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               rx_ready <= 1'b0;
               busy     <= 1'b0;
               if (start_load) begin
                  // start_load outranks a pending paint, which stays pending
                  state_r     <= ST_SYNC;
                  pixel_count <= 19'd0;
                  rx_ready    <= 1'b1;
                  busy        <= 1'b1;
               end else if (paint_req && !paint_ack) begin
                  // the !paint_ack guard stops a still-held request from being served twice
                  paint_ack  <= 1'b1;
                  bram_we    <= paint_in_range_s;
                  bram_addr  <= paint_addr_s;
                  bram_wdata <= {5'd0, paint_color};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SYNC: begin
               if (accept_s && (rx_data == SYNC_BYTE)) begin
                  state_r <= ST_LOAD;
                  addr_r  <= 19'd0;
`ifdef PACKED_INPUT_EN
                  phase_r <= 2'd0;
`endif
               end else begin
                  state_r <= ST_SYNC;
               end
            end
            ST_LOAD: begin
`ifdef PACKED_INPUT_EN
               if (phase_r == 2'd1) begin
                  bram_we     <= 1'b1;
                  bram_addr   <= addr_r;
                  bram_wdata  <= {5'd0, low_pix_r};
                  addr_r      <= addr_r + 19'd1;
                  pixel_count <= pixel_count + 19'd1;
                  phase_r     <= 2'd2;
                  if (addr_r == LAST_ADDR) begin
                     state_r    <= ST_DONE;
                     frame_done <= 1'b1;
                     phase_r    <= 2'd0;
                  end
               end else if (phase_r == 2'd2) begin
                  rx_ready <= 1'b1;
                  phase_r  <= 2'd0;
               end else if (accept_s) begin
                  bram_we     <= 1'b1;
                  bram_addr   <= addr_r;
                  bram_wdata  <= {5'd0, rx_data[6:4]};
                  low_pix_r   <= rx_data[2:0];
                  addr_r      <= addr_r + 19'd1;
                  pixel_count <= pixel_count + 19'd1;
                  rx_ready    <= 1'b0;
                  phase_r     <= 2'd1;
               end else begin
                  phase_r <= 2'd0;
               end
`else
               if (accept_s) begin
                  bram_we     <= 1'b1;
                  bram_addr   <= addr_r;
                  bram_wdata  <= {5'd0, rx_data[2:0]};
                  addr_r      <= addr_r + 19'd1;
                  pixel_count <= pixel_count + 19'd1;
                  if (addr_r == LAST_ADDR) begin
                     state_r    <= ST_DONE;
                     rx_ready   <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
`endif
            end
            ST_DONE: begin
               state_r  <= ST_IDLE;
               rx_ready <= 1'b0;
               busy     <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               rx_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_image_writer.sv
// Testbench for bram_image_writer: directed steps with a scoreboard queue of
// expected BRAM writes that a negedge monitor pops and compares.
module tb_bram_image_writer;

   localparam int IMG_W = 640;
   localparam int IMG_H = 4;
   localparam int FRAME = IMG_W * IMG_H;

   logic        clk_25mhz = 1'b0;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        start_load;
   logic        paint_req;
   logic [9:0]  paint_x;
   logic [9:0]  paint_y;
   logic [2:0]  paint_color;
   logic        paint_ack;
   logic        bram_we;
   logic [18:0] bram_addr;
   logic [7:0]  bram_wdata;
   logic        busy;
   logic        frame_done;
   logic [18:0] pixel_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [26:0] exp_q[$];
   logic        ack_allowed = 1'b0;

   bram_image_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk_25mhz  (clk_25mhz),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .start_load (start_load),
      .paint_req  (paint_req),
      .paint_x    (paint_x),
      .paint_y    (paint_y),
      .paint_color(paint_color),
      .paint_ack  (paint_ack),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .busy       (busy),
      .frame_done (frame_done),
      .pixel_count(pixel_count)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // write monitor: every strobe must match the head of the scoreboard
   always @(negedge clk_25mhz) begin
      if (reset_n === 1'b1 && bram_we === 1'b1) begin
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed addr %0d data %0h expected no write", bram_addr, bram_wdata);
         end
         if (exp_q.size() != 0) begin
            logic [26:0] e;
            e = exp_q.pop_front();
            assert ({bram_addr, bram_wdata} === e) else begin
               n_fail++;
               $error("FAIL write: observed addr %0d data %0h expected addr %0d data %0h",
                      bram_addr, bram_wdata, e[26:8], e[7:0]);
            end
         end
      end
      if (reset_n === 1'b1 && paint_ack === 1'b1 && !ack_allowed) begin
         n_tests++;
         assert (ack_allowed) else begin
            n_fail++;
            $error("FAIL stray_ack: observed paint_ack 1 expected 0");
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk_25mhz);
      start_load = 1'b1;
      @(posedge clk_25mhz);
      #1 start_load = 1'b0;
   endtask

   // drive one byte once rx_ready is high; returns 1 time unit after acceptance
   task automatic send_byte(input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk_25mhz);
      while (rx_ready !== 1'b1 && n < 50) begin
         @(negedge clk_25mhz);
         n++;
      end
      if (rx_ready !== 1'b1) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      rx_data  = d;
      rx_valid = 1'b1;
      @(posedge clk_25mhz);
      #1 rx_valid = 1'b0;
   endtask

   // load bytes for addresses first..first+count-1, with one stall along the way
   task automatic load_bytes(input int first, input int count, input int seed);
      logic [7:0] d;
      for (int i = first; i < first + count; i++) begin
         d = 8'((i * seed) + 3);
         exp_q.push_back({19'(i), 5'd0, d[2:0]});
         send_byte(d);
         if (i == first + 100) repeat (4) @(negedge clk_25mhz);
      end
   endtask

   task automatic do_paint(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c,
                           input logic [18:0] addr, input logic hit);
      int n;
      @(negedge clk_25mhz);
      if (hit) exp_q.push_back({addr, 5'd0, c});
      paint_x = x; paint_y = y; paint_color = c;
      paint_req = 1'b1;
      ack_allowed = 1'b1;
      n = 0;
      @(negedge clk_25mhz);
      while (paint_ack !== 1'b1 && n < 20) begin
         @(negedge clk_25mhz);
         n++;
      end
      chk("paint_ack_latency", n, 0);
      chk("paint_we", {31'd0, bram_we}, {31'd0, hit});
      paint_req = 1'b0;
      @(negedge clk_25mhz);
      chk("paint_ack_pulse", {31'd0, paint_ack}, 32'd0);
      ack_allowed = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; start_load = 1'b0;
      paint_req = 1'b0; paint_x = 10'd0; paint_y = 10'd0; paint_color = 3'd0;
      #50;
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_bram_we", {31'd0, bram_we}, 32'd0);
      chk("rst_bram_addr", {13'd0, bram_addr}, 32'd0);
      chk("rst_bram_wdata", {24'd0, bram_wdata}, 32'd0);
      chk("rst_flags", {29'd0, paint_ack, frame_done, busy}, 32'd0);
      chk("rst_pixel_count", {13'd0, pixel_count}, 32'd0);
      @(negedge clk_25mhz);
      reset_n = 1'b1;
      @(negedge clk_25mhz);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);

`ifdef PACKED_INPUT_EN
      pulse_start();
      send_byte(8'hAA);
      exp_q.push_back({19'd0, 8'h06});
      exp_q.push_back({19'd1, 8'h03});
      send_byte(8'h63);
      @(negedge clk_25mhz);
      chk("pk_ready_first", {31'd0, rx_ready}, 32'd0);
      @(negedge clk_25mhz);
      chk("pk_ready_second", {31'd0, rx_ready}, 32'd0);
      chk("pk_second_we", {31'd0, bram_we}, 32'd1);
      @(negedge clk_25mhz);
      chk("pk_ready_back", {31'd0, rx_ready}, 32'd1);
      chk("pk_pixel_count", {13'd0, pixel_count}, 32'd2);
`else
      // sync hunt, first pixels, then the rest of the frame
      pulse_start();
      @(negedge clk_25mhz);
      chk("sync_busy", {31'd0, busy}, 32'd1);
      chk("sync_rx_ready", {31'd0, rx_ready}, 32'd1);
      chk("sync_pixel_count", {13'd0, pixel_count}, 32'd0);
      send_byte(8'h11);
      send_byte(8'hAA);
      exp_q.push_back({19'd0, 8'h05});
      send_byte(8'h05);
      exp_q.push_back({19'd1, 8'h02});
      send_byte(8'h02);
      @(negedge clk_25mhz);
      chk("load_pixel_count", {13'd0, pixel_count}, 32'd2);
      chk("load_busy", {31'd0, busy}, 32'd1);
      load_bytes(2, FRAME - 2, 37);
      @(negedge clk_25mhz);
      chk("last_addr", {13'd0, bram_addr}, FRAME - 1);
      chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd1);
      @(negedge clk_25mhz);
      chk("frame_done_end", {31'd0, frame_done}, 32'd0);
      chk("after_busy", {31'd0, busy}, 32'd0);
      chk("frame_pixel_count", {13'd0, pixel_count}, FRAME);
      chk("after_rx_ready", {31'd0, rx_ready}, 32'd0);
      @(negedge clk_25mhz);
      chk("count_hold", {13'd0, pixel_count}, FRAME);

      // paints: last pixel, shift-add path, two out-of-range requests
      do_paint(10'd639, 10'd3, 3'b101, 19'(FRAME - 1), 1'b1);
      do_paint(10'd0, 10'd1, 3'b011, 19'd640, 1'b1);
      do_paint(10'd640, 10'd0, 3'b111, 19'd0, 1'b0);
      do_paint(10'd5, 10'd4, 3'b001, 19'd0, 1'b0);

      // start_load beats a simultaneous paint; paint serviced after frame
      @(negedge clk_25mhz);
      paint_x = 10'd2; paint_y = 10'd2; paint_color = 3'b111;
      paint_req = 1'b1; start_load = 1'b1;
      @(posedge clk_25mhz);
      #1 start_load = 1'b0;
      @(negedge clk_25mhz);
      chk("conflict_busy", {31'd0, busy}, 32'd1);
      chk("conflict_no_ack", {31'd0, paint_ack}, 32'd0);
      send_byte(8'hAA);
      load_bytes(0, FRAME, 11);
      @(negedge clk_25mhz);
      chk("frame2_done", {31'd0, frame_done}, 32'd1);
      exp_q.push_back({19'd1282, 8'h07});
      ack_allowed = 1'b1;
      @(negedge clk_25mhz);
      chk("frame2_count", {13'd0, pixel_count}, FRAME);
      chk("frame2_idle_no_ack", {31'd0, paint_ack}, 32'd0);
      @(negedge clk_25mhz);
      chk("pending_paint_ack", {31'd0, paint_ack}, 32'd1);
      chk("pending_paint_we", {31'd0, bram_we}, 32'd1);
      paint_req = 1'b0;
      @(negedge clk_25mhz);
      ack_allowed = 1'b0;

      // reset in the middle of a load, then restart from address 0
      pulse_start();
      send_byte(8'hAA);
      load_bytes(0, 1000, 5);
      @(negedge clk_25mhz);
      #5 reset_n = 1'b0;
      #1;
      chk("midreset_outputs",
          {rx_ready, bram_we, bram_addr, bram_wdata, paint_ack, frame_done, busy, pixel_count}, 32'd0);
      @(negedge clk_25mhz);
      reset_n = 1'b1;
      pulse_start();
      send_byte(8'hAA);
      load_bytes(0, 1, 9);
      @(negedge clk_25mhz);
      chk("restart_pixel_count", {13'd0, pixel_count}, 32'd1);
      chk("restart_addr", {13'd0, bram_addr}, 32'd0);
`endif
      repeat (2) @(negedge clk_25mhz);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
